// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption sequencer: owns the state and round-key
// registers and steps one shared round datapath through all ten rounds.
//
// state | meaning
// IDLE  | waiting for a block; in_ready high
// RUN   | one round per clock, round_q = 1..10
// DONE  | ciphertext on data_out until the consumer takes it
module aes_round_sequencer #(
  parameter int KEY_LENGTH = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic [7:0]   rnd_rcon,
  output logic         rnd_final,
  input  logic [127:0] key_next,
  input  logic [127:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy,
  output logic [3:0]   round_cnt
);

  localparam int NUM_ROUNDS = (KEY_LENGTH == 128) ? 10 : 0;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  generate
    if (KEY_LENGTH != 128) begin : g_bad_key_length
      $error("aes_round_sequencer: only KEY_LENGTH = 128 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;

  // Multiply by x in GF(2^8) with the AES polynomial; generates the Rcon chain.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Next-state decode: accept in IDLE, iterate in RUN, hand off in DONE.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = data_in ^ key;
          key_d   = key;
          rcon_d  = 8'h01;
          round_d = 4'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = rnd_result;
        key_d   = key_next;
        rcon_d  = xtime(rcon_q);
        // The last round leaves round_cnt parked at 10 for the DONE phase.
        if (round_q == LAST_ROUND) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          round_d = 4'd0;
          fsm_d   = IDLE;
        end
      end
      default: begin
        fsm_d   = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // All sequencer state; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      rcon_q  <= 8'h00;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
    end
  end

  // Handshake and status decode straight from the state register.
  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  // round_q also reads 10 in DONE, so qualify with RUN.
  assign rnd_final = (fsm_q == RUN) && (round_q == LAST_ROUND);

  assign rnd_state = state_q;
  assign rnd_key   = key_q;
  assign rnd_rcon  = rcon_q;
  assign data_out  = state_q;
  assign round_cnt = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: supplies a behavioural AES round unit and
// key-expansion unit around the sequencer and checks against a full AES model.
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] key;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic [7:0]   rnd_rcon;
  logic         rnd_final;
  logic [127:0] key_next;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;
  logic [3:0]   round_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [79:0]  RCON_SEQ = 80'h01_02_04_08_10_20_40_80_1b_36;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_round_sequencer #(.KEY_LENGTH(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .key        (key),
    .rnd_state  (rnd_state),
    .rnd_key    (rnd_key),
    .rnd_rcon   (rnd_rcon),
    .rnd_final  (rnd_final),
    .key_next   (key_next),
    .rnd_result (rnd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .busy       (busy),
    .round_cnt  (round_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse (b^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv, base, e;
    inv = 8'h01; base = b; e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // SubBytes + ShiftRows; byte i of the block sits at row i%4, column i/4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return t;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0] a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      t[127-32*c -: 8] = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
      t[119-32*c -: 8] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
      t[111-32*c -: 8] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
      t[103-32*c -: 8] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
    end
    return t;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, tmp, n0, n1, n2, n3;
    w3  = k[31:0];
    tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ tmp;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin,
                                             input logic [127:0] rk);
    logic [127:0] t;
    t = sub_shift(s);
    if (!fin) t = mix_columns(t);
    return t ^ rk;
  endfunction

  // Reference: whole-block AES-128 encryption with a fixed Rcon table.
  function automatic logic [127:0] aes_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [127:0] s, rk;
    s = pt ^ k; rk = k;
    for (int r = 0; r < 10; r++) begin
      rk = expand_key(rk, RCON_SEQ[79-8*r -: 8]);
      s  = aes_round(s, r == 9, rk);
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round datapath the sequencer drives.
  assign key_next   = expand_key(rnd_key, rnd_rcon);
  assign rnd_result = aes_round(rnd_state, rnd_final, key_next);

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic start_block(input logic [127:0] k, input logic [127:0] pt);
    @(negedge clk);
    in_valid = 1'b1; data_in = pt; key = k;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // n counts clock edges from the accept edge (inclusive) to first out_valid.
  task automatic wait_out_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, busy, rnd_final, round_cnt, rnd_rcon} !== {4'b1000, 4'd0, 8'h00}) begin
      errors++;
      $display("FAIL reset_status: got rdy/vld/busy/fin/round/rcon=%b%b%b%b/%0d/%h exp 1000/0/00",
               in_ready, out_valid, busy, rnd_final, round_cnt, rnd_rcon);
    end
    checks++;
    if (data_out !== 128'h0) begin
      errors++; $display("FAIL reset_data_out: got %h exp 0", data_out);
    end
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, out_valid, in_ready, round_cnt} !== {3'b001, 4'd0}) begin
        errors++;
        $display("FAIL idle_status cyc %0d: got busy/vld/rdy/round=%b%b%b/%0d exp 001/0",
                 i, busy, out_valid, in_ready, round_cnt);
      end
      checks++;
      if ({rnd_state, rnd_key, rnd_rcon} !== {256'h0, 8'h00}) begin
        errors++;
        $display("FAIL idle_regs cyc %0d: got state=%h key=%h rcon=%h exp all zero",
                 i, rnd_state, rnd_key, rnd_rcon);
      end
    end
  endtask

  task automatic test_fips_c1();
    int n;
    out_ready = 1'b1;
    start_block(C1_KEY, C1_PT);
    wait_out_valid(n);
    checks++;
    if (n !== 11) begin
      errors++; $display("FAIL c1_latency: got %0d cycles exp 11", n);
    end
    checks++;
    if (data_out !== C1_CT) begin
      errors++; $display("FAIL c1_data_out: got %h exp %h", data_out, C1_CT);
    end
    checks++;
    if (data_out !== aes_encrypt(C1_KEY, C1_PT)) begin
      errors++; $display("FAIL c1_model: got %h exp %h", data_out, aes_encrypt(C1_KEY, C1_PT));
    end
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL c1_return_idle: got rdy/vld/busy=%b%b%b exp 100", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_fips_b_rcon_final();
    logic [7:0] exp_rc;
    out_ready = 1'b1;
    start_block(B_KEY, B_PT);
    for (int i = 0; i < 10; i++) begin
      exp_rc = RCON_SEQ[79-8*i -: 8];
      checks++;
      if ({busy, out_valid, in_ready, round_cnt, rnd_rcon, rnd_final} !==
          {3'b100, 4'(i + 1), exp_rc, (i == 9)}) begin
        errors++;
        $display("FAIL b_run_cycle %0d: got busy/vld/rdy=%b%b%b round=%0d rcon=%h fin=%b exp 100 round=%0d rcon=%h fin=%b",
                 i + 1, busy, out_valid, in_ready, round_cnt, rnd_rcon, rnd_final, i + 1, exp_rc, i == 9);
      end
      @(negedge clk);
    end
    checks++;
    if ({out_valid, rnd_final, in_ready, round_cnt} !== {3'b100, 4'd10}) begin
      errors++;
      $display("FAIL b_done_status: got vld/fin/rdy=%b%b%b round=%0d exp 100 round=10",
               out_valid, rnd_final, in_ready, round_cnt);
    end
    checks++;
    if (data_out !== B_CT) begin
      errors++; $display("FAIL b_data_out: got %h exp %h", data_out, B_CT);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [127:0] k, pt, exp_ct;
    int n;
    k = rand128(); pt = rand128(); exp_ct = aes_encrypt(k, pt);
    out_ready = 1'b0;
    start_block(k, pt);
    wait_out_valid(n);
    checks++;
    if (n !== 11) begin
      errors++; $display("FAIL bp_latency: got %0d cycles exp 11", n);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({out_valid, in_ready, busy, round_cnt} !== {3'b101, 4'd10} || data_out !== exp_ct) begin
        errors++;
        $display("FAIL bp_hold cyc %0d: got vld/rdy/busy=%b%b%b round=%0d data=%h exp 101 round=10 data=%h",
                 i, out_valid, in_ready, busy, round_cnt, data_out, exp_ct);
      end
      in_valid = 1'b1; data_in = rand128(); key = rand128();
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, round_cnt} !== {3'b100, 4'd0}) begin
      errors++;
      $display("FAIL bp_release: got rdy/vld/busy=%b%b%b round=%0d exp 100 round=0",
               in_ready, out_valid, busy, round_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (data_out !== exp_ct || busy !== 1'b0) begin
        errors++; $display("FAIL bp_idle_hold cyc %0d: got data=%h busy=%b exp data=%h busy=0",
                           i, data_out, busy, exp_ct);
      end
    end
  endtask

  task automatic test_ignore_inputs();
    logic [127:0] k, pt, exp_ct;
    int n;
    out_ready = 1'b1;
    for (int blk = 0; blk < 3; blk++) begin
      k = rand128(); pt = rand128(); exp_ct = aes_encrypt(k, pt);
      start_block(k, pt);
      for (int i = 0; i < 8; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        data_in = rand128(); key = rand128();
        @(negedge clk);
      end
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (out_valid !== 1'b1 || data_out !== exp_ct) begin
        errors++; $display("FAIL ignore_result blk %0d: got vld=%b data=%h exp vld=1 data=%h",
                           blk, out_valid, data_out, exp_ct);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ks[3], pts[3], exps[3];
    logic [127:0] got_q[$];
    int acc_q[$];
    int b;
    for (int i = 0; i < 3; i++) begin
      ks[i] = rand128(); pts[i] = rand128(); exps[i] = aes_encrypt(ks[i], pts[i]);
    end
    out_ready = 1'b1;
    b = 0;
    @(negedge clk);
    in_valid = 1'b1; data_in = pts[0]; key = ks[0];
    for (int c = 0; c < 80 && got_q.size() < 3; c++) begin
      if (out_valid) got_q.push_back(data_out);
      if (in_ready && in_valid) begin
        acc_q.push_back(c);
        b++;
      end
      @(negedge clk);
      if (b < 3) begin
        data_in = pts[b]; key = ks[b];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc_q.size() !== 3 || got_q.size() !== 3) begin
      errors++; $display("FAIL b2b_counts: got accepts=%0d results=%0d exp 3/3", acc_q.size(), got_q.size());
    end
    for (int i = 0; i + 1 < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i+1] - acc_q[i] !== 12) begin
        errors++; $display("FAIL b2b_spacing %0d: got %0d cycles exp 12", i, acc_q[i+1] - acc_q[i]);
      end
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exps[i]) begin
        errors++; $display("FAIL b2b_result %0d: got %h exp %h", i, got_q[i], exps[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    out_ready = 1'b1;
    start_block(B_KEY, B_PT);
    n = 0;
    while (round_cnt !== 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (round_cnt !== 4'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_reach_round5: got round=%0d busy=%b exp 5/1", round_cnt, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, rnd_final, round_cnt, rnd_rcon} !== {4'b1000, 4'd0, 8'h00} ||
        data_out !== 128'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got rdy/vld/busy/fin=%b%b%b%b round=%0d rcon=%h data=%h exp 1000/0/00/0",
               in_ready, out_valid, busy, rnd_final, round_cnt, rnd_rcon, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_block(B_KEY, B_PT);
    wait_out_valid(n);
    checks++;
    if (n !== 11 || data_out !== B_CT) begin
      errors++; $display("FAIL rst_mid_after: got lat=%0d data=%h exp lat=11 data=%h", n, data_out, B_CT);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    data_in = '0; key = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_reset();
    test_idle_hold();
    test_fips_c1();
    test_fips_b_rcon_final();
    test_backpressure();
    test_ignore_inputs();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
